// File: rtl/sar_comp_ctrl.sv
// MSB-first successive-approximation controller driving the comparator's probe
// operand and recovering the unknown operand from its eq/gt/lt flags.
module sar_comp_ctrl #(
  parameter int WIDTH = 4,
  parameter int SW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             aeqb,
  input  logic             agtb,
  input  logic             altb,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [SW-1:0]    steps
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] probe_r, probe_s, result_r, result_s, trial_s, bit_s;
  logic [IW-1:0]    idx_r, idx_s;
  logic [SW-1:0]    steps_r, steps_s;
  logic             busy_r, done_r, err_r, err_s;
  logic             flags_ok_s, decide_s;

  function automatic logic one_hot3(input logic [2:0] f);
    case (f)
      3'b100, 3'b010, 3'b001: one_hot3 = 1'b1;
      default:                one_hot3 = 1'b0;
    endcase
  endfunction

  // Trial value keeps the current bit on gt and clears it on lt.
  always_comb begin
    flags_ok_s = one_hot3({aeqb, agtb, altb});
    bit_s      = {{(WIDTH-1){1'b0}}, 1'b1} << idx_r;
    if (altb) begin
      trial_s = probe_r & ~bit_s;
    end else begin
      trial_s = probe_r;
    end
    decide_s = !flags_ok_s || aeqb || (idx_r == IW'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (abort) begin
          state_s = IDLE;
        end else if (start) begin
          state_s = SEARCH;
        end else begin
          state_s = IDLE;
        end
      end
      SEARCH: begin
        if (abort) begin
          state_s = IDLE;
        end else if (decide_s) begin
          state_s = DONE;
        end else begin
          state_s = SEARCH;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered datapath; abort leaves everything untouched.
  always_comb begin
    probe_s  = probe_r;
    idx_s    = idx_r;
    result_s = result_r;
    steps_s  = steps_r;
    err_s    = err_r;
    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          probe_s = {1'b1, {(WIDTH-1){1'b0}}};
          idx_s   = IW'(WIDTH - 1);
          steps_s = {SW{1'b0}};
          err_s   = 1'b0;
        end else begin
          probe_s = probe_r;
        end
      end
      SEARCH: begin
        if (abort) begin
          probe_s = probe_r;
        end else begin
          if (steps_r == SW'(WIDTH)) begin
            steps_s = steps_r;
          end else begin
            steps_s = steps_r + SW'(1);
          end
          if (!flags_ok_s) begin
            err_s    = 1'b1;
            result_s = {WIDTH{1'b0}};
          end else if (aeqb) begin
            result_s = probe_r;
          end else if (idx_r == IW'(0)) begin
            if (altb) begin
              result_s = trial_s;
            end else begin
              err_s    = 1'b1;
              result_s = {WIDTH{1'b0}};
            end
          end else begin
            probe_s = trial_s | (bit_s >> 1);
            idx_s   = idx_r - IW'(1);
          end
        end
      end
      DONE:    probe_s = probe_r;
      default: probe_s = probe_r;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      probe_r  <= {WIDTH{1'b0}};
      idx_r    <= {IW{1'b0}};
      result_r <= {WIDTH{1'b0}};
      steps_r  <= {SW{1'b0}};
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      probe_r  <= probe_s;
      idx_r    <= idx_s;
      result_r <= result_s;
      steps_r  <= steps_s;
      err_r    <= err_s;
      busy_r   <= (state_s == SEARCH);
      done_r   <= (state_s == DONE);
    end
  end

  assign probe  = probe_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign err    = err_r;
  assign result = result_r;
  assign steps  = steps_r;

endmodule
